// File: rtl/aibcr3aux_osc_freq_meter.sv
// Aux oscillator frequency meter: counts rising edges of a selected divided oscillator clock over a
// programmable clkin window. Optional limit comparison enabled by AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN.
module aibcr3aux_osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             por,
  inout  wire              vcc_aibcr3aux,
  inout  wire              vss_aibcr3aux,
  input  logic             osc_divby16,
  input  logic             osc_divby32,
  input  logic             osc_divby64,
  input  logic [1:0]       div_sel,
  input  logic             meas_start,
  input  logic [WIN_W-1:0] win_len,
`ifdef AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN
  input  logic [CNT_W-1:0] lim_min,
  input  logic [CNT_W-1:0] lim_max,
  output logic             meas_pass,
`endif
  output logic             meas_busy,
  output logic             meas_done,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_ovf
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  // Supply pins carry no logic; tie them off into a deliberately unused net.
  wire unused_supply = vcc_aibcr3aux ^ vss_aibcr3aux;

  logic [2:0] osc_raw;
  logic [2:0] osc_sync;
  assign osc_raw = {osc_divby64, osc_divby32, osc_divby16};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      always_ff @(posedge clkin) begin
        if (por) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], osc_raw[gi]};
        end
      end
      assign osc_sync[gi] = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  state_t           state_reg;
  logic [1:0]       sel_reg;
  logic [WIN_W-1:0] win_len_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             sel_prev_reg;
  logic             sel_sync;
  logic             rise;
  logic             last_win;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // Reserved select code 3 falls through to divby16.
  always_comb begin
    case (sel_reg)
      2'd1:    sel_sync = osc_sync[1];
      2'd2:    sel_sync = osc_sync[2];
      default: sel_sync = osc_sync[0];
    endcase
  end

  assign rise     = sel_sync & ~sel_prev_reg;
  assign last_win = (win_cnt_reg == win_len_reg - WIN_W'(1));

  // Saturating count: an edge arriving at all-ones is dropped and flagged.
  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (rise) begin
      if (cnt_reg == '1) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

`ifdef AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN
  logic [CNT_W-1:0] lim_min_reg;
  logic [CNT_W-1:0] lim_max_reg;
  logic             pass_next;
  assign pass_next = ~ovf_next & (cnt_next >= lim_min_reg) & (cnt_next <= lim_max_reg);
`endif

  always_ff @(posedge clkin) begin
    if (por) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      win_len_reg  <= '0;
      win_cnt_reg  <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      sel_prev_reg <= 1'b0;
      meas_busy    <= 1'b0;
      meas_done    <= 1'b0;
      meas_count   <= '0;
      meas_ovf     <= 1'b0;
`ifdef AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN
      lim_min_reg  <= '0;
      lim_max_reg  <= '0;
      meas_pass    <= 1'b0;
`endif
    end else begin
      // Tracks the selected source every cycle, so ARM primes it from the newly latched source.
      sel_prev_reg <= sel_sync;
      meas_done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (meas_start) begin
            sel_reg     <= div_sel;
            win_len_reg <= win_len;
`ifdef AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN
            lim_min_reg <= lim_min;
            lim_max_reg <= lim_max;
`endif
            meas_busy   <= 1'b1;
            state_reg   <= ARM;
          end
        end
        ARM: begin
          cnt_reg     <= '0;
          ovf_reg     <= 1'b0;
          win_cnt_reg <= '0;
          if (win_len_reg == '0) begin
            meas_count <= '0;
            meas_ovf   <= 1'b0;
`ifdef AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN
            // A zero count is always <= lim_max, so only the lower bound matters.
            meas_pass  <= (lim_min_reg == '0);
`endif
            meas_done  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            state_reg <= MEAS;
          end
        end
        MEAS: begin
          cnt_reg     <= cnt_next;
          ovf_reg     <= ovf_next;
          win_cnt_reg <= win_cnt_reg + WIN_W'(1);
          if (last_win) begin
            meas_count <= cnt_next;
            meas_ovf   <= ovf_next;
`ifdef AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN
            meas_pass  <= pass_next;
`endif
            meas_done  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: begin
          meas_busy <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aibcr3aux_osc_freq_meter.md
Name: aibcr3aux_osc_freq_meter

Overview:
- Downstream consumer of the aux oscillator monitor's divided outputs (divby16/32/64).
- Counts rising edges of one selected divided oscillator clock over a programmable window of reference-clock cycles.
- Result is a frequency code for the aux controller and for test readout.
- Single reference clock domain; the divided oscillator inputs are asynchronous and are synchronized internally.

Parameters:
- CNT_W, 16, width of the edge counter and of meas_count.
- WIN_W, 16, width of the window-length input.
- SYNC_STAGES, 2, synchronizer depth per oscillator input (legal range 2-3).

Ports:
- clkin  input  1  reference clock; all state on its rising edge.
- por  input  1  reset; synchronous, active-high.
- vcc_aibcr3aux  inout  1  supply; no logic function.
- vss_aibcr3aux  inout  1  ground; no logic function.
- osc_divby16  input  1  async divided oscillator clock (divide by 16).
- osc_divby32  input  1  async divided oscillator clock (divide by 32).
- osc_divby64  input  1  async divided oscillator clock (divide by 64).
- div_sel  input  2  source select: 0 = divby16, 1 = divby32, 2 = divby64, 3 = reserved, treated as 0.
- meas_start  input  1  start request; single-cycle pulse or level.
- win_len  input  WIN_W  window length in clkin cycles.
- meas_busy  output  1  measurement in progress.
- meas_done  output  1  one-cycle pulse when the result is valid.
- meas_count  output  CNT_W  edge count from the last measurement.
- meas_ovf  output  1  counter saturated in the last measurement.

Behaviour:
- Reset: when por=1 at a clkin edge, all outputs go to 0, FSM goes to IDLE, and synchronizers and edge history clear.
- Each osc input has its own SYNC_STAGES flop synchronizer. The mux selects between synchronized signals, never raw inputs.
- Edge detect: rise = sel_sync & ~sel_prev, where sel_prev is registered every cycle.
- FSM states: IDLE, ARM, MEAS, DONE.
- IDLE:
  - meas_busy=0.
  - meas_start=1 latches div_sel and win_len into internal registers and goes to ARM.
  - If latched win_len==0, go directly to DONE with count 0, ovf 0.
- ARM:
  - One cycle. Loads sel_prev from the selected synced value so a source change cannot register a false edge.
  - Clears the counter and window timer; goes to MEAS.
  - meas_busy=1 from ARM through DONE.
- MEAS:
  - Lasts exactly latched win_len cycles.
  - Each cycle with rise=1 increments the counter.
  - At all-ones the counter holds and the ovf flag sets.
  - On the last window cycle, that cycle's rise is counted, then go to DONE.
- DONE:
  - One cycle. meas_done=1; meas_count and meas_ovf update on entry, so they are valid in the same cycle as meas_done.
  - Goes to IDLE.
- Latency: start sampled at edge N → ARM at N+1 → MEAS N+2..N+1+win_len → DONE at N+2+win_len.
- meas_count and meas_ovf hold their value until the next DONE. They are not cleared on start.
- meas_start during ARM, MEAS or DONE is ignored. No queuing.
- div_sel and win_len changes during a measurement have no effect; the values are latched at start.
- por=1 mid-measurement aborts: no meas_done pulse, and outputs return to reset values.
- Accuracy: ±1 count due to window alignment. Input high and low times must each exceed SYNC_STAGES+1 clkin periods, otherwise counts are under-reported. This is not flagged.

Optional Feature:
- Macro: AIBCR3AUX_OSC_FREQ_LIMIT_CHECK_EN.
- Defined:
  - Extra inputs lim_min[CNT_W-1:0] and lim_max[CNT_W-1:0], sampled at start.
  - Extra output meas_pass, updated in DONE: meas_pass = ~ovf & (count >= lim_min) & (count <= lim_max).
  - meas_pass holds like meas_count and resets to 0.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- divby16 toggling with 20 clkin period, div_sel=0, win_len=1000, start → meas_done at start+1002 cycles, meas_count=50±1, meas_ovf=0.
- Same stimulus, div_sel=2 with divby64 period 80 → meas_count=12±1; then div_sel=1 with period 40 → 25±1. No spurious extra count on the source switch.
- win_len=0, start → DONE 2 cycles after start, meas_count=0, meas_done single pulse, meas_busy high 2 cycles.
- CNT_W=4, period 4, win_len=200 → meas_count=15, meas_ovf=1; a next run with win_len=20 → meas_ovf=0, count=5±1.
- Start pulses during MEAS and por asserted at mid-window → extra starts ignored; after por all outputs 0, no meas_done; a fresh start completes normally.
- With the macro defined: lim_min=45, lim_max=55, expected 50 → meas_pass=1; lim_max=40 → meas_pass=0; any overflow run → meas_pass=0.
